// File: rtl/rob_pkg.sv
// Shared defaults and entry bookkeeping types for the reorder buffer.
package rob_pkg;

  localparam int unsigned ROB_DEPTH  = 16;
  localparam int unsigned ROB_DATA_W = 32;
  localparam int unsigned ROB_ADDR_W = 32;
  localparam int unsigned ROB_REG_W  = 5;

  typedef enum logic {
    KindReg   = 1'b0,
    KindStore = 1'b1
  } rob_kind_e;

  typedef struct packed {
    logic      valid;
    logic      done;
    rob_kind_e kind;
    logic      pred;
    logic      taken;
  } rob_flags_t;

  function automatic logic is_mispredict(input rob_flags_t e);
    return e.taken != e.pred;
  endfunction

endpackage

// File: rtl/rob_ptr.sv
// Wrap-around circular-buffer pointer with increment and synchronous clear.
module rob_ptr #(
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [TAG_W-1:0] ptr
);

  logic [TAG_W-1:0] ptr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (clr) begin
      ptr_q <= '0;
    end else if (inc) begin
      ptr_q <= ptr_q + {{(TAG_W-1){1'b0}}, 1'b1};
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/reorder_buffer.sv
// In-order commit reorder buffer: allocates in program order, accepts out-of-order
// writebacks, commits one entry per cycle and flushes on a mispredicted branch.
module reorder_buffer
  import rob_pkg::*;
#(
  parameter int unsigned DEPTH  = ROB_DEPTH,
  parameter int unsigned DATA_W = ROB_DATA_W,
  parameter int unsigned ADDR_W = ROB_ADDR_W,
  parameter int unsigned REG_W  = ROB_REG_W,
  localparam int unsigned TAG_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              alloc_valid,
  output logic              alloc_ready,
  input  logic [REG_W-1:0]  alloc_rd,
  input  logic              alloc_store,
  input  logic              alloc_pred,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              wb0_valid,
  input  logic [TAG_W-1:0]  wb0_tag,
  input  logic [DATA_W-1:0] wb0_data,
  input  logic              wb0_taken,
  input  logic [ADDR_W-1:0] wb0_pc,
  input  logic              wb1_valid,
  input  logic [TAG_W-1:0]  wb1_tag,
  input  logic [DATA_W-1:0] wb1_data,
  input  logic [TAG_W-1:0]  q0_tag,
  input  logic [TAG_W-1:0]  q1_tag,
  output logic              q0_ready,
  output logic              q1_ready,
  output logic [DATA_W-1:0] q0_data,
  output logic [DATA_W-1:0] q1_data,
  output logic              rf_we,
  output logic [REG_W-1:0]  rf_rd,
  output logic [DATA_W-1:0] rf_data,
  output logic [TAG_W-1:0]  rf_tag,
  output logic              st_commit,
  output logic [TAG_W-1:0]  st_tag,
  output logic              flush,
  output logic [ADDR_W-1:0] flush_pc
);

  logic [TAG_W-1:0]  head, tail;
  logic [TAG_W:0]    count_q, count_d;
  rob_flags_t        flags_q [DEPTH];
  rob_flags_t        flags_d [DEPTH];
  logic [REG_W-1:0]  rd_q    [DEPTH];
  logic [DATA_W-1:0] data_q  [DEPTH];
  logic [ADDR_W-1:0] pc_q    [DEPTH];

  logic              active, clr, alloc_fire, wb0_hit, wb1_hit;
  logic              commit_fire, commit_store, mispredict;
  rob_flags_t        head_e;
  logic              rf_we_q, st_commit_q, flush_q;
  logic [REG_W-1:0]  rf_rd_q;
  logic [DATA_W-1:0] rf_data_q;
  logic [TAG_W-1:0]  rf_tag_q, st_tag_q;
  logic [ADDR_W-1:0] flush_pc_q;

  // The flush cycle blocks every update except the wholesale clear.
  assign active       = rdy & ~flush_q;
  assign clr          = rdy & flush_q;
  assign alloc_ready  = active & ~rst & (count_q < (TAG_W+1)'(DEPTH));
  assign alloc_fire   = alloc_valid & alloc_ready;
  assign alloc_tag    = tail;

  assign wb0_hit      = active & wb0_valid & flags_q[wb0_tag].valid;
  assign wb1_hit      = active & wb1_valid & flags_q[wb1_tag].valid &
                        ~(wb0_valid & (wb0_tag == wb1_tag));

  assign head_e       = flags_q[head];
  assign commit_fire  = active & head_e.valid & head_e.done;
  assign commit_store = head_e.kind == KindStore;
  assign mispredict   = commit_fire & is_mispredict(head_e);

  rob_ptr #(.TAG_W(TAG_W)) u_head (
    .clk (clk),
    .rst (rst),
    .inc (commit_fire),
    .clr (clr),
    .ptr (head)
  );

  rob_ptr #(.TAG_W(TAG_W)) u_tail (
    .clk (clk),
    .rst (rst),
    .inc (alloc_fire),
    .clr (clr),
    .ptr (tail)
  );

  always_comb begin
    flags_d = flags_q;
    if (clr) begin
      flags_d = '{default: '0};
    end else if (active) begin
      if (alloc_fire) begin
        flags_d[tail] = '{valid: 1'b1, done: 1'b0, kind: rob_kind_e'(alloc_store),
                          pred: alloc_pred, taken: 1'b0};
      end
      if (wb0_hit) begin
        flags_d[wb0_tag].done  = 1'b1;
        flags_d[wb0_tag].taken = wb0_taken;
      end
      if (wb1_hit) flags_d[wb1_tag].done = 1'b1;
      if (commit_fire) flags_d[head].valid = 1'b0;
    end
  end

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (active) begin
      count_d = count_q + {{TAG_W{1'b0}}, alloc_fire} - {{TAG_W{1'b0}}, commit_fire};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= '{default: '0};
      count_q <= '0;
    end else begin
      flags_q <= flags_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q   <= '{default: '0};
      data_q <= '{default: '0};
      pc_q   <= '{default: '0};
    end else if (active) begin
      if (alloc_fire) rd_q[tail] <= alloc_rd;
      if (wb0_hit) begin
        data_q[wb0_tag] <= wb0_data;
        pc_q[wb0_tag]   <= wb0_pc;
      end
      if (wb1_hit) data_q[wb1_tag] <= wb1_data;
    end
  end

  // Strobes hold while rdy is low and are masked at the output instead.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we_q     <= 1'b0;
      st_commit_q <= 1'b0;
      flush_q     <= 1'b0;
      rf_rd_q     <= '0;
      rf_data_q   <= '0;
      rf_tag_q    <= '0;
      st_tag_q    <= '0;
      flush_pc_q  <= '0;
    end else if (rdy) begin
      rf_we_q     <= commit_fire & ~commit_store;
      st_commit_q <= commit_fire & commit_store;
      flush_q     <= mispredict;
      if (commit_fire & ~commit_store) begin
        rf_rd_q   <= rd_q[head];
        rf_data_q <= data_q[head];
        rf_tag_q  <= head;
      end
      if (commit_fire & commit_store) st_tag_q <= head;
      if (mispredict) flush_pc_q <= pc_q[head];
    end
  end

  assign rf_we     = rf_we_q & rdy;
  assign st_commit = st_commit_q & rdy;
  assign flush     = flush_q & rdy;
  assign rf_rd     = rf_rd_q;
  assign rf_data   = rf_data_q;
  assign rf_tag    = rf_tag_q;
  assign st_tag    = st_tag_q;
  assign flush_pc  = flush_pc_q;

  always_comb begin
    q0_ready = flags_q[q0_tag].valid & (flags_q[q0_tag].done |
               (wb0_hit & (wb0_tag == q0_tag)) | (wb1_hit & (wb1_tag == q0_tag)));
    if (wb0_hit && (wb0_tag == q0_tag))      q0_data = wb0_data;
    else if (wb1_hit && (wb1_tag == q0_tag)) q0_data = wb1_data;
    else                                     q0_data = data_q[q0_tag];

    q1_ready = flags_q[q1_tag].valid & (flags_q[q1_tag].done |
               (wb0_hit & (wb0_tag == q1_tag)) | (wb1_hit & (wb1_tag == q1_tag)));
    if (wb0_hit && (wb0_tag == q1_tag))      q1_data = wb0_data;
    else if (wb1_hit && (wb1_tag == q1_tag)) q1_data = wb1_data;
    else                                     q1_data = data_q[q1_tag];
  end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 Parameter DEPTH, default 16, entry count; power of two, 4..64.
REQ-002 Parameter DATA_W, default 32, result/data width.
REQ-003 Parameter ADDR_W, default 32, redirect PC width.
REQ-004 Parameter REG_W, default 5, architectural register index width; TAG_W = log2(DEPTH) is derived.
REQ-005 Clocking: one clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 rdy  in  1  global enable; when low, no state changes and all strobes are low.
REQ-009 alloc_valid  in  1  decode requests one entry.
REQ-010 alloc_ready  out  1  entry free this cycle.
REQ-011 alloc_rd / alloc_store / alloc_pred  in  REG_W/1/1  destination register, store flag, predicted-taken.
REQ-012 alloc_tag  out  TAG_W  tag granted on handshake (equals tail pointer).
REQ-013 wb0_valid, wb0_tag, wb0_data, wb0_taken, wb0_pc  in  1/TAG_W/DATA_W/1/ADDR_W  ALU/branch writeback.
REQ-014 wb1_valid, wb1_tag, wb1_data  in  1/TAG_W/DATA_W  load/store-buffer writeback.
REQ-015 q0_tag, q1_tag  in  TAG_W  operand lookups; q0_ready, q1_ready out 1; q0_data, q1_data out DATA_W.
REQ-016 rf_we, rf_rd, rf_data, rf_tag  out  1/REG_W/DATA_W/TAG_W  register commit.
REQ-017 st_commit, st_tag  out  1/TAG_W  store release to store buffer.
REQ-018 flush, flush_pc  out  1/ADDR_W  mispredict flush and redirect target.

Function
REQ-019 Circular FIFO; head/tail pointers TAG_W bits, wrap DEPTH-1 -> 0; occupancy counter TAG_W+1 bits.
REQ-020 alloc_ready = rdy & !flush & (count < DEPTH); computed from registered count, no same-cycle commit bypass.
REQ-021 Handshake (alloc_valid & alloc_ready): entry[tail] written valid, done=0, fields stored; tail+1; count+1.
REQ-022 Writeback to a valid entry sets done, data; wb0 also stores taken and pc; writeback to an invalid entry ignored.
REQ-023 wb0 and wb1 to the same tag in one cycle: wb0 wins.
REQ-024 Lookups combinational: ready = entry valid & (done | matching wb this cycle); data bypasses wb0 over wb1 over stored.
REQ-025 Commit at most one entry per cycle: when head valid and done, registered outputs next edge.
REQ-026 Store head: st_commit=1, st_tag=head, rf_we=0; non-store head: rf_we=1, rf_rd/data/tag from entry; rd=0 still reported.
REQ-027 Committed entry invalidated, head+1, count-1; alloc and commit same cycle leave count unchanged.
REQ-028 Committing head with taken != pred: flush=1 and flush_pc=pc for exactly one cycle, registered.
REQ-029 Cycle flush is high: all entries invalid, head=tail=0, count=0; no alloc, writeback or commit accepted.
REQ-030 rf_we, st_commit, flush are single-cycle strobes, low otherwise.
REQ-031 Non-branch entries: pred=0 at alloc, taken=0 unless wb0 sets it; never flush.

Reset
REQ-032 rst asserted: immediately all entries invalid, head=tail=count=0, all outputs 0 (alloc_ready 0 until rst deasserts).
REQ-033 Reset mid-operation discards in-flight entries; no commit strobe emitted for them.

Structure
REQ-034 Package rob_pkg holds default DEPTH/DATA_W/ADDR_W/REG_W, entry record typedef and the store-flag encoding.
REQ-035 One sub-module rob_ptr: TAG_W wrap-around pointer with increment and clear, instantiated for head and tail.

Verification
REQ-036 Fill: 16 allocs, rdy=1, no wb -> tags 0..15, alloc_ready 0 after 16th, count 16.
REQ-037 Out-of-order wb: tags 0,1,2 allocated, wb1 tag2 then wb0 tag0 then tag1 -> commits tag0,1,2 on consecutive cycles, in order.
REQ-038 Mispredict: tag3 pred=0, wb0 taken=1 pc=0x1000 -> flush 1 cycle with flush_pc 0x1000, count 0, next alloc_tag 0.
REQ-039 Wrap: 20 alloc/commit pairs at DEPTH=16 -> tags wrap 15->0, count never exceeds 1, no data corruption.
REQ-040 Bypass: q0_tag=5 during wb0 tag5 data 0xDEAD -> q0_ready 1, q0_data 0xDEAD same cycle; store tag6 -> st_commit, rf_we 0.
